// File: rtl/ga_phase_controller.sv
// ga_phase_controller: generation sequencer stepping INIT -> EVAL -> SORT -> MUTATE with stop conditions and a phase watchdog
module ga_phase_controller #(
  parameter int                           primaryInputCount = 8,
  parameter logic [primaryInputCount+1:0] TARGET_FITNESS    = 10'd256,
  parameter logic [15:0]                  MAX_GENERATIONS   = 16'd1000,
  parameter logic [23:0]                  PHASE_TIMEOUT     = 24'hFFFFFF
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         init_done,
  input  logic                         eval_done,
  input  logic [3:0]                   state_sortFSM,
  input  logic                         mutate_done,
  input  logic [primaryInputCount+1:0] best_fitness,
  output logic [2:0]                   state_controller,
  output logic [15:0]                  generation,
  output logic                         busy,
  output logic                         solved,
  output logic                         timeout_err
);
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    SORT   = 3'b001,
    EVAL   = 3'b010,
    MUTATE = 3'b011,
    INIT   = 3'b100,
    FINISH = 3'b101,
    ERROR  = 3'b111
  } state_t;
  state_t      state;
  logic [23:0] phase_cnt;
  logic        sort_fin;
  logic        phase_done;
  logic        wd_hit;
  logic        last_gen;
  logic [15:0] gen_next;
  assign state_controller = state;
  assign sort_fin = state_sortFSM == 4'b1000;
  assign gen_next = &generation ? generation : generation + 16'd1;
  assign last_gen = {1'b0, generation} + 17'd1 == {1'b0, MAX_GENERATIONS};
  // the watchdog fires on the cycle whose increment would bring the counter to PHASE_TIMEOUT-1
  assign wd_hit = phase_cnt == PHASE_TIMEOUT - 24'd2;
  // completion strobe belonging to the current phase; done pulses from other phases are ignored
  always_comb
    phase_done = state == INIT   ? init_done :
                 state == EVAL   ? eval_done :
                 state == SORT   ? sort_fin :
                 state == MUTATE ? mutate_done : 1'b0;
  // phase sequencing, generation counting, stop flags and watchdog
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      generation  <= '0;
      busy        <= 1'b0;
      solved      <= 1'b0;
      timeout_err <= 1'b0;
      phase_cnt   <= '0;
    end else begin
      case (state)
        IDLE, FINISH, ERROR:
          if (start) begin
            state       <= INIT;
            busy        <= 1'b1;
            generation  <= '0;
            solved      <= 1'b0;
            timeout_err <= 1'b0;
            phase_cnt   <= '0;
          end
        INIT, EVAL, SORT, MUTATE:
          if (phase_done) begin
            phase_cnt <= '0;
            case (state)
              INIT: state <= EVAL;
              EVAL: state <= SORT;
              MUTATE: begin
                state      <= EVAL;
                generation <= gen_next;
              end
              default:
                if (best_fitness >= TARGET_FITNESS) begin
                  state      <= FINISH;
                  busy       <= 1'b0;
                  solved     <= 1'b1;
                  generation <= gen_next;
                end else if (last_gen) begin
                  state      <= FINISH;
                  busy       <= 1'b0;
                  generation <= gen_next;
                end else begin
                  state <= MUTATE;
                end
            endcase
          end else if (wd_hit) begin
            state       <= ERROR;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            phase_cnt   <= '0;
          end else begin
            phase_cnt <= phase_cnt + 24'd1;
          end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          phase_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ga_phase_controller.sv
// tb_ga_phase_controller: scoreboard bench with a phase-level reference model and randomized stimulus
module tb_ga_phase_controller;
  localparam int MAXG = 7;
  localparam int TO   = 16;
  localparam int TGT  = 256;
  localparam int C_IDLE = 0, C_SORT = 1, C_EVAL = 2, C_MUT = 3, C_INIT = 4, C_FIN = 5, C_ERR = 7;
  typedef struct {
    int st;
    int gen;
    bit b;
    bit s;
    bit t;
  } exp_t;
  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        init_done = 1'b0;
  logic        eval_done = 1'b0;
  logic [3:0]  state_sortFSM = 4'd0;
  logic        mutate_done = 1'b0;
  logic [9:0]  best_fitness = 10'd0;
  logic [2:0]  state_controller;
  logic [15:0] generation;
  logic        busy;
  logic        solved;
  logic        timeout_err;
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          m_ph = C_IDLE, m_gen = 0, m_cyc = 0;
  bit          m_sol = 0, m_terr = 0;
  ga_phase_controller #(
    .primaryInputCount(8),
    .TARGET_FITNESS(10'd256),
    .MAX_GENERATIONS(16'(MAXG)),
    .PHASE_TIMEOUT(24'(TO))
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .start(start),
    .init_done(init_done),
    .eval_done(eval_done),
    .state_sortFSM(state_sortFSM),
    .mutate_done(mutate_done),
    .best_fitness(best_fitness),
    .state_controller(state_controller),
    .generation(generation),
    .busy(busy),
    .solved(solved),
    .timeout_err(timeout_err)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endfunction
  function automatic exp_t cur_exp();
    exp_t e;
    e.st  = m_ph;
    e.gen = m_gen;
    e.b   = m_ph inside {C_INIT, C_EVAL, C_SORT, C_MUT};
    e.s   = m_sol;
    e.t   = m_terr;
    return e;
  endfunction
  function automatic void compare(input string tag, input exp_t e);
    check({tag, ".state"}, int'(state_controller), e.st);
    check({tag, ".generation"}, int'(generation), e.gen);
    check({tag, ".busy"}, int'(busy), int'(e.b));
    check({tag, ".solved"}, int'(solved), int'(e.s));
    check({tag, ".timeout_err"}, int'(timeout_err), int'(e.t));
  endfunction
  function automatic void model_reset();
    m_ph = C_IDLE; m_gen = 0; m_cyc = 0; m_sol = 0; m_terr = 0;
  endfunction
  // one clock of the phase rules: what the controller should show after the coming edge
  function automatic void model_step(input bit s, input bit i, input bit e, input int sf, input bit m, input int bf);
    bit done;
    if (!(m_ph inside {C_INIT, C_EVAL, C_SORT, C_MUT})) begin
      if (s) begin
        m_ph = C_INIT; m_gen = 0; m_sol = 0; m_terr = 0; m_cyc = 0;
      end
      return;
    end
    done = (m_ph == C_INIT && i) || (m_ph == C_EVAL && e) || (m_ph == C_SORT && sf == 8) || (m_ph == C_MUT && m);
    m_cyc++;
    if (done) begin
      m_cyc = 0;
      if (m_ph == C_INIT) m_ph = C_EVAL;
      else if (m_ph == C_EVAL) m_ph = C_SORT;
      else if (m_ph == C_MUT) begin
        m_ph = C_EVAL;
        if (m_gen < 65535) m_gen++;
      end else if (bf >= TGT) begin
        m_sol = 1;
        if (m_gen < 65535) m_gen++;
        m_ph = C_FIN;
      end else if (m_gen + 1 == MAXG) begin
        m_gen++;
        m_ph = C_FIN;
      end else m_ph = C_MUT;
    end else if (m_cyc == TO - 1) begin
      m_ph = C_ERR; m_terr = 1; m_cyc = 0;
    end
  endfunction
  task automatic cyc(input bit s, input bit i, input bit e, input logic [3:0] sf, input bit m, input logic [9:0] bf);
    @(negedge CLOCK_50);
    start = s; init_done = i; eval_done = e; state_sortFSM = sf; mutate_done = m; best_fitness = bf;
    model_step(s, i, e, int'(sf), m, int'(bf));
    exp_q.push_back(cur_exp());
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 4'd0, 0, 10'd0);
  endtask
  // reset raised between edges: outputs must clear without waiting for a clock
  task automatic do_reset();
    @(negedge CLOCK_50);
    start = 0; init_done = 0; eval_done = 0; state_sortFSM = 0; mutate_done = 0; best_fitness = 0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare("async_reset", cur_exp());
    exp_q.push_back(cur_exp());
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask
  // monitor: every edge presents a new output set, compared against the oldest queued expectation
  initial begin
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (exp_q.size() > 0) compare("cycle", exp_q.pop_front());
    end
  end
  initial begin
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    model_reset();
    compare("reset", cur_exp());
    reset = 1'b0;
    cyc(1, 0, 0, 4'd0, 0, 10'd0);
    idle(2);
    cyc(0, 1, 0, 4'd0, 0, 10'd0);
    idle(1);
    cyc(0, 0, 1, 4'd0, 0, 10'd0);
    cyc(0, 0, 0, 4'd3, 0, 10'd0);
    cyc(0, 0, 0, 4'b1000, 0, 10'd256);
    idle(2);
    cyc(1, 0, 0, 4'd0, 0, 10'd0);
    cyc(0, 0, 1, 4'd0, 1, 10'd0);
    cyc(0, 1, 0, 4'd0, 0, 10'd0);
    cyc(0, 0, 1, 4'd0, 0, 10'd0);
    for (int g = 0; g < MAXG; g++) begin
      cyc(1, 0, 0, 4'd2, 0, 10'd300);
      cyc(0, 0, 0, 4'b1000, 0, 10'd10);
      if (g < MAXG - 1) begin
        cyc(0, 0, 1, 4'd0, 0, 10'd0);
        cyc(0, 0, 0, 4'd0, 1, 10'd0);
        cyc(0, 0, 1, 4'd0, 0, 10'd0);
      end
    end
    idle(2);
    cyc(1, 0, 0, 4'd0, 0, 10'd0);
    cyc(0, 1, 0, 4'd0, 0, 10'd0);
    idle(20);
    cyc(1, 0, 0, 4'd0, 0, 10'd0);
    cyc(0, 1, 0, 4'd0, 0, 10'd0);
    idle(TO - 2);
    cyc(0, 0, 1, 4'd0, 0, 10'd0);
    for (int g = 0; g < 5; g++) begin
      cyc(0, 0, 0, 4'b1000, 0, 10'd10);
      cyc(0, 0, 0, 4'd0, 1, 10'd0);
      cyc(0, 0, 1, 4'd0, 0, 10'd0);
    end
    cyc(0, 0, 0, 4'b1000, 0, 10'd10);
    idle(1);
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0 ? 4'b1000 : 4'($urandom_range(0, 7)),
               $urandom_range(0, 3) == 0, 10'($urandom_range(200, 300)));
    end
    @(posedge CLOCK_50);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
